// File: rtl/clahe_pkg.sv
// Shared constants, state encoding and mask helper for the bitmap index encoder.
package clahe_pkg;

  localparam int N_BITS = 32;
  localparam int IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  function automatic logic [N_BITS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_BITS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/priority_encoder_32_5.sv
// Combinational 32-to-5 priority encoder with selectable scan order,
// plus any-bit-set and exactly-one-bit-set flags.
module priority_encoder_32_5
  import clahe_pkg::*;
(
  input  logic [N_BITS-1:0] vec_i,
  input  logic              lsb_first_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o,
  output logic              single_o
);

  // Later loop iterations override earlier ones, so the scan runs toward the winning end.
  always_comb begin
    idx_o = '0;
    if (lsb_first_i) begin
      for (int i = N_BITS - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < N_BITS; i++) begin
        if (vec_i[i]) idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o    = |vec_i;
  assign single_o = any_o && ((vec_i & (vec_i - N_BITS'(1))) == '0);

endmodule

// File: rtl/bitmap_index_encoder.sv
// Sequential bitmap-to-index encoder: takes a multi-hot bitmap and streams the
// index of each set bit, one per beat, then pulses done.
module bitmap_index_encoder
  import clahe_pkg::*;
#(
  parameter int N_BITS    = clahe_pkg::N_BITS,
  parameter int IDX_W     = clahe_pkg::IDX_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [N_BITS-1:0] load_bitmap,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic [IDX_W-1:0]  idx_data,
  output logic              idx_last,
  output logic              done,
  output logic              busy
);

  // Both streams: a beat transfers on a rising edge where valid && ready are high;
  // once valid is raised it stays high with stable data until that transfer.

  enc_state_e        state_q, state_d;
  logic [N_BITS-1:0] pending_q, pending_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  enc_idx;
  logic              enc_any;
  logic              enc_single;

  priority_encoder_32_5 u_penc (
    .vec_i       (pending_q),
    .lsb_first_i (LSB_FIRST),
    .idx_o       (enc_idx),
    .any_o       (enc_any),
    .single_o    (enc_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          pending_d = load_bitmap;
          if (load_bitmap != '0) state_d = EMIT;
          else                   done_d  = 1'b1;
        end
      end
      EMIT: begin
        if (idx_ready) begin
          pending_d = pending_q & ~onehot(enc_idx);
          if (enc_single) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so no ready/load input reaches them.
  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == EMIT);
    idx_valid  = busy && enc_any;
    idx_data   = busy ? enc_idx : '0;
    idx_last   = idx_valid && enc_single;
    done       = done_q;
  end

endmodule

// File: tb/tb_bitmap_index_encoder.sv
// Randomized scoreboard bench: two encoders (ascending and descending order)
// share one stimulus stream and are checked against a bitmap-level model.
module tb_bitmap_index_encoder;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_bitmap;
  logic        idx_ready;

  logic        load_ready_a, idx_valid_a, idx_last_a, done_a, busy_a;
  logic [4:0]  idx_data_a;
  logic        load_ready_b, idx_valid_b, idx_last_b, done_b, busy_b;
  logic [4:0]  idx_data_b;

  int checks = 0;
  int errors = 0;

  // {last, descending index, ascending index}
  logic [10:0] exp_q[$];
  int          asc_l[$];
  logic        done_exp;
  logic        acc_flag;
  logic [10:0] e;
  int          rdy_mode;

  bitmap_index_encoder #(.N_BITS(32), .IDX_W(5), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_a),
    .load_bitmap(load_bitmap), .idx_valid(idx_valid_a), .idx_ready(idx_ready),
    .idx_data(idx_data_a), .idx_last(idx_last_a), .done(done_a), .busy(busy_a)
  );

  bitmap_index_encoder #(.N_BITS(32), .IDX_W(5), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_bitmap(load_bitmap), .idx_valid(idx_valid_b), .idx_ready(idx_ready),
    .idx_data(idx_data_b), .idx_last(idx_last_b), .done(done_b), .busy(busy_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load_ready_a"}, load_ready_a, 1);
    chk({tag, "_idx_valid_a"},  idx_valid_a,  0);
    chk({tag, "_idx_data_a"},   idx_data_a,   0);
    chk({tag, "_idx_last_a"},   idx_last_a,   0);
    chk({tag, "_done_a"},       done_a,       0);
    chk({tag, "_busy_a"},       busy_a,       0);
    chk({tag, "_load_ready_b"}, load_ready_b, 1);
    chk({tag, "_idx_valid_b"},  idx_valid_b,  0);
    chk({tag, "_done_b"},       done_b,       0);
    chk({tag, "_busy_b"},       busy_b,       0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Model: the block is busy exactly while expected beats remain queued.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_exp = 1'b0;
      chk_reset_outputs("rst");
    end else begin
      chk("load_ready_a", load_ready_a, exp_q.size() == 0);
      chk("load_ready_b", load_ready_b, exp_q.size() == 0);
      chk("busy_a", busy_a, exp_q.size() != 0);
      chk("busy_b", busy_b, exp_q.size() != 0);
      chk("idx_valid_a", idx_valid_a, exp_q.size() != 0);
      chk("idx_valid_b", idx_valid_b, exp_q.size() != 0);
      chk("done_a", done_a, done_exp);
      chk("done_b", done_b, done_exp);
      done_exp = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("idx_data_a", idx_data_a, e[4:0]);
        chk("idx_data_b", idx_data_b, e[9:5]);
        chk("idx_last_a", idx_last_a, e[10]);
        chk("idx_last_b", idx_last_b, e[10]);
        if (idx_ready) begin
          void'(exp_q.pop_front());
          if (e[10]) done_exp = 1'b1;
        end
      end else if (load_valid) begin
        asc_l.delete();
        for (int i = 0; i < 32; i++) if (load_bitmap[i]) asc_l.push_back(i);
        for (int j = 0; j < asc_l.size(); j++)
          exp_q.push_back({j == asc_l.size() - 1, 5'(asc_l[asc_l.size() - 1 - j]), 5'(asc_l[j])});
        if (asc_l.size() == 0) done_exp = 1'b1;
        acc_flag = 1'b1;
      end
    end
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       idx_ready = 1'b1;
      1:       idx_ready = ~idx_ready;
      default: idx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic load(input logic [31:0] bm);
    int n;
    acc_flag    = 1'b0;
    load_valid  = 1'b1;
    load_bitmap = bm;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!acc_flag && n < 500);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL load_timeout bitmap 0x%0h: got no acceptance expected acceptance", bm);
    end
    #1;
    load_valid  = 1'b0;
    load_bitmap = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    load_valid  = 1'b0;
    load_bitmap = '0;
    idx_ready   = 1'b1;
    rdy_mode    = 0;
    done_exp    = 1'b0;
    acc_flag    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    load(32'h0000_0001);
    wait_idle();
    load(32'h8000_0011);
    wait_idle();
    load(32'h0000_0000);
    load(32'h0000_0002);
    wait_idle();

    rdy_mode = 1;
    load(32'hFFFF_FFFF);
    wait_idle();

    rdy_mode = 2;
    load(32'h0000_0F00);
    load(32'h0000_0001);
    wait_idle();

    rdy_mode = 0;
    load(32'h0000_00FF);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(32'h0000_0004);
    wait_idle();

    for (int t = 0; t < 40; t++) begin
      logic [31:0] bm;
      int          sel;
      rdy_mode = $urandom_range(0, 2);
      sel      = $urandom_range(0, 9);
      if (sel == 0)      bm = 32'h0;
      else if (sel == 1) bm = 32'h1 << $urandom_range(0, 31);
      else               bm = $urandom & $urandom;
      load(bm);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitmap_index_encoder.md
Name: bitmap_index_encoder

Overview:
- Sequential 32-to-5 encoder. Accepts a 32-bit multi-hot bitmap, for example histogram-bin or tile-bank flags produced by the CLAHE datapath.
- Emits the 5-bit index of every set bit, one per beat, over a valid/ready stream. Lowest index first by default.
- Inverse companion of the 5-to-32 one-hot decoder used for bank/bin write selection. Converts flag vectors back into bin addresses for the clip-redistribution and mapping stages.

Parameters:
- N_BITS, 32, width of the input bitmap.
- IDX_W, 5, index width; must equal clog2(N_BITS).
- LSB_FIRST, 1, scan order. 1 = ascending index; 0 = descending index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  bitmap offered.
- load_ready  output  1  block can accept a bitmap (high only in IDLE).
- load_bitmap  input  N_BITS  flags to encode. Sampled on load handshake.
- idx_valid  output  1  idx_data holds a valid index.
- idx_ready  input  1  consumer accepts the index.
- idx_data  output  IDX_W  index of the current set bit.
- idx_last  output  1  high with the final index of the current bitmap.
- done  output  1  one-cycle pulse when a bitmap is fully drained. Also pulses for an all-zero bitmap.
- busy  output  1  high in EMIT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0. Output reset values: load_ready=1, idx_valid=0, idx_data=0, idx_last=0, done=0, busy=0.
- States are IDLE and EMIT.
- IDLE:
  - load_ready=1.
  - On load_valid&load_ready at edge t: pending<=load_bitmap.
  - If load_bitmap != 0: go to EMIT. idx_valid rises at t+1.
  - If load_bitmap == 0: stay in IDLE. done pulses at t+1. No index beat is produced.
- EMIT:
  - idx_valid=1 and load_ready=0.
  - idx_data = lowest set bit of pending (LSB_FIRST=1) or highest set bit (LSB_FIRST=0).
  - idx_last=1 when pending has exactly one bit set.
- Pop: on idx_valid&idx_ready, the emitted bit is cleared (pending <= pending & ~onehot(idx_data)).
  - If idx_last was 1: go to IDLE. done pulses in the following cycle. load_ready is 1 in that same following cycle.
- Stream rules:
  - While idx_valid=1 and idx_ready=0, idx_data and idx_last hold stable.
  - idx_valid never drops without a handshake.
- Throughput: one index per cycle while idx_ready is held high. A bitmap with k set bits drains in k cycles after the first valid.
- No bitmap overlap: a new load is accepted only in IDLE. Earliest acceptance is the cycle after the last pop.
  - load_valid asserted during EMIT is ignored (not accepted, not stored).
- Combinational paths:
  - idx_valid, idx_data, idx_last, load_ready, busy and done are decoded from registered state and pending only.
  - There is no combinational path from idx_ready or load_* to any output.
- Full bitmap 0xFFFF_FFFF: 32 beats. Indices 0..31 ascending (LSB_FIRST=1), idx_last on 31.
- Single-bit bitmap: one beat with idx_last=1.
- Reset mid-EMIT: pending is discarded and outputs return to reset values immediately. No done pulse is generated.
- X/Z on load_bitmap is only permitted while load_valid=0. Undriven inputs are not decoded.

Decomposition:
- Shared package (clahe_pkg) holds:
  - constants N_BITS=32 and IDX_W=5;
  - state enum (IDLE, EMIT);
  - a function onehot(idx) returning the N_BITS mask.
- One natural sub-module: priority_encoder_32_5.
  - Combinational; input N_BITS vector plus order select.
  - Outputs IDX_W index, any flag, and single-bit flag.
  - The top holds only the FSM, pending register, and handshake logic.

Test Plan:
- Load 0x0000_0001 with idx_ready=1: one beat idx_data=0 with idx_last=1 at t+1; done at t+2; load_ready=1 at t+2.
- Load 0x8000_0011 with LSB_FIRST=1 and ready=1: indices 0, 4, 31 on consecutive cycles, idx_last only on 31. With LSB_FIRST=0: indices 31, 4, 0.
- Load 0x0000_0000: no idx_valid; done pulse at t+1; second load accepted at t+1.
- Load 0xFFFF_FFFF with idx_ready toggling 1,0,1,0: exactly 32 beats, indices 0..31 in order, data held stable through every stall, 63 cycles from first valid to last pop.
- Load 0x0000_0F00 with load_valid held high during EMIT carrying 0x1: the 0x1 bitmap is not accepted until after the beat for index 11 (idx_last); then index 0 is emitted.
- Assert rst_n=0 after two pops of 0x0000_00FF: idx_valid=0, load_ready=1 and done=0 immediately. After release, load 0x4 yields the single index 2 with no leftover indices.
